// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I types and constants for the decode stage.
//   word_t      - 32-bit machine word
//   alu_op_t    - ALU operation select
//   OPCODE_*    - major opcode field values (ir[6:0])
//   F3_*        - funct3 values for OP / OP-IMM
//   idex_t      - ID/EX pipeline register payload
package riscv_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_OP2  = 4'd10
  } alu_op_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef struct packed {
    alu_op_t     alu_op;
    word_t       op1;
    word_t       op2;
    word_t       store_data;
    logic [4:0]  rd;
    logic        wen;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    word_t       pc;
    logic        illegal;
  } idex_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction.
//   i_ir    in  instruction bits [31:7] (opcode field not needed)
//   o_imm_i out I-type immediate, sign-extended
//   o_imm_s out S-type immediate, sign-extended
//   o_imm_u out U-type immediate (upper 20 bits, low 12 zero)
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] i_ir,
  output word_t       o_imm_i,
  output word_t       o_imm_s,
  output word_t       o_imm_u
);

  assign o_imm_i = {{20{i_ir[31]}}, i_ir[31:20]};
  assign o_imm_s = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
  assign o_imm_u = {i_ir[31:12], 12'b0};

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode / operand select feeding the ALU.
//   clk, reset             clock, synchronous active-high reset
//   if_valid/if_ready      fetch handshake; if_ir, if_pc instruction + address
//   rs1_addr/rs2_addr      register-file read addresses; rs1_data/rs2_data read data
//   mem_* / wb_*           later-stage writeback candidates used for forwarding
//   flush                  drop held and incoming instruction
//   ex_ready               execute stage accepts ID/EX contents
//   ex_*                   ID/EX pipeline register outputs
module decode_stage
  import riscv_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_valid,
  output logic       if_ready,
  input  word_t      if_ir,
  input  word_t      if_pc,
  output logic [4:0] rs1_addr,
  output logic [4:0] rs2_addr,
  input  word_t      rs1_data,
  input  word_t      rs2_data,
  input  logic       mem_wen,
  input  logic [4:0] mem_rd,
  input  word_t      mem_data,
  input  logic       wb_wen,
  input  logic [4:0] wb_rd,
  input  word_t      wb_data,
  input  logic       flush,
  input  logic       ex_ready,
  output logic       ex_valid,
  output alu_op_t    ex_alu_op,
  output word_t      ex_op1,
  output word_t      ex_op2,
  output word_t      ex_store_data,
  output logic [4:0] ex_rd,
  output logic       ex_wen,
  output logic       ex_mem_read,
  output logic       ex_mem_write,
  output logic [2:0] ex_funct3,
  output word_t      ex_pc,
  output logic       ex_illegal
);

  logic       r_valid;
  idex_t      r_idex;
  idex_t      w_dec;
  word_t      w_imm_i, w_imm_s, w_imm_u;
  word_t      w_fwd1, w_fwd2;
  logic [6:0] w_opcode, w_f7;
  logic [2:0] w_f3;
  logic       w_illegal, w_wen;
  logic       w_rs1_used, w_rs2_used;
  logic       w_adv, w_load_use, w_new_valid;

  assign w_opcode = if_ir[6:0];
  assign w_f3     = if_ir[14:12];
  assign w_f7     = if_ir[31:25];
  assign rs1_addr = if_ir[19:15];
  assign rs2_addr = if_ir[24:20];

  imm_gen u_imm_gen (
    .i_ir    (if_ir[31:7]),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_u (w_imm_u)
  );

  function automatic word_t fwd(input logic [4:0] reg_a, input word_t rf_data,
                                input logic m_wen, input logic [4:0] m_rd, input word_t m_data,
                                input logic w_en, input logic [4:0] w_rd, input word_t w_data);
    if (reg_a == 5'd0)                 return '0;
    else if (m_wen && (m_rd == reg_a)) return m_data;
    else if (w_en && (w_rd == reg_a))  return w_data;
    else                               return rf_data;
  endfunction

  assign w_fwd1 = fwd(rs1_addr, rs1_data, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
  assign w_fwd2 = fwd(rs2_addr, rs2_data, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);

  assign w_rs1_used = (w_opcode != OPCODE_LUI) && (w_opcode != OPCODE_AUIPC);
  assign w_rs2_used = (w_opcode == OPCODE_OP) || (w_opcode == OPCODE_STORE);

  assign w_load_use = r_valid && r_idex.mem_read && (r_idex.rd != 5'd0) &&
                      ((w_rs1_used && (r_idex.rd == rs1_addr)) ||
                       (w_rs2_used && (r_idex.rd == rs2_addr)));
  assign w_adv       = !r_valid || ex_ready;
  assign if_ready    = w_adv && !w_load_use;
  assign w_new_valid = if_valid && !w_load_use && !flush;

  always_comb begin
    w_dec            = '0;
    w_dec.alu_op     = ALU_ADD;
    w_dec.op1        = w_fwd1;
    w_dec.store_data = w_fwd2;
    w_dec.rd         = if_ir[11:7];
    w_dec.funct3     = w_f3;
    w_dec.pc         = if_pc;
    w_illegal        = 1'b0;
    w_wen            = 1'b0;
    case (w_opcode)
      OPCODE_OP: begin
        w_dec.op2 = w_fwd2;
        w_wen     = 1'b1;
        case (w_f3)
          F3_ADD_SUB: w_dec.alu_op = w_f7[5] ? ALU_SUB : ALU_ADD;
          F3_SLL:     w_dec.alu_op = ALU_SLL;
          F3_SLT:     w_dec.alu_op = ALU_SLT;
          F3_SLTU:    w_dec.alu_op = ALU_SLTU;
          F3_XOR:     w_dec.alu_op = ALU_XOR;
          F3_SRL_SRA: w_dec.alu_op = w_f7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:      w_dec.alu_op = ALU_OR;
          default:    w_dec.alu_op = ALU_AND;
        endcase
        // funct7=0x20 is only meaningful for SUB and SRA
        if (!((w_f7 == 7'h00) ||
              ((w_f7 == 7'h20) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SRL_SRA)))))
          w_illegal = 1'b1;
      end
      OPCODE_OP_IMM: begin
        w_dec.op2 = w_imm_i;
        w_wen     = 1'b1;
        case (w_f3)
          F3_ADD_SUB: w_dec.alu_op = ALU_ADD;
          F3_SLL: begin
            w_dec.alu_op = ALU_SLL;
            w_dec.op2    = {27'b0, if_ir[24:20]};
            if (w_f7 != 7'h00) w_illegal = 1'b1;
          end
          F3_SLT:  w_dec.alu_op = ALU_SLT;
          F3_SLTU: w_dec.alu_op = ALU_SLTU;
          F3_XOR:  w_dec.alu_op = ALU_XOR;
          F3_SRL_SRA: begin
            w_dec.alu_op = if_ir[30] ? ALU_SRA : ALU_SRL;
            w_dec.op2    = {27'b0, if_ir[24:20]};
            if (if_ir[31] || (if_ir[29:25] != 5'd0)) w_illegal = 1'b1;
          end
          F3_OR:   w_dec.alu_op = ALU_OR;
          default: w_dec.alu_op = ALU_AND;
        endcase
      end
      OPCODE_LUI: begin
        w_dec.alu_op = ALU_OP2;
        w_dec.op2    = w_imm_u;
        w_wen        = 1'b1;
      end
      OPCODE_AUIPC: begin
        w_dec.op1 = if_pc;
        w_dec.op2 = w_imm_u;
        w_wen     = 1'b1;
      end
      OPCODE_LOAD: begin
        w_dec.op2      = w_imm_i;
        w_dec.mem_read = 1'b1;
        w_wen          = 1'b1;
      end
      OPCODE_STORE: begin
        w_dec.op2       = w_imm_s;
        w_dec.mem_write = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_wen           = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
    end
    w_dec.illegal = w_illegal;
    w_dec.wen     = w_wen && (w_dec.rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_idex    <= '0;
      r_idex.pc <= RESET_PC;
    end else if (flush || (w_adv && !w_new_valid)) begin
      // bubble: payload held, only side-effecting controls dropped
      r_valid          <= 1'b0;
      r_idex.wen       <= 1'b0;
      r_idex.mem_read  <= 1'b0;
      r_idex.mem_write <= 1'b0;
    end else if (w_adv) begin
      r_valid <= 1'b1;
      r_idex  <= w_dec;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_idex.alu_op;
  assign ex_op1        = r_idex.op1;
  assign ex_op2        = r_idex.op2;
  assign ex_store_data = r_idex.store_data;
  assign ex_rd         = r_idex.rd;
  assign ex_wen        = r_idex.wen;
  assign ex_mem_read   = r_idex.mem_read;
  assign ex_mem_write  = r_idex.mem_write;
  assign ex_funct3     = r_idex.funct3;
  assign ex_pc         = r_idex.pc;
  assign ex_illegal    = r_idex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import riscv_pkg::*;

  localparam word_t RST_PC = 32'h0000_0080;

  logic       clk = 1'b0;
  logic       reset, if_valid, if_ready;
  word_t      if_ir, if_pc, rs1_data, rs2_data, mem_data, wb_data;
  logic [4:0] rs1_addr, rs2_addr, mem_rd, wb_rd, ex_rd;
  logic       mem_wen, wb_wen, flush, ex_ready, ex_valid;
  alu_op_t    ex_alu_op;
  word_t      ex_op1, ex_op2, ex_store_data, ex_pc;
  logic       ex_wen, ex_mem_read, ex_mem_write, ex_illegal;
  logic [2:0] ex_funct3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_ir(if_ir), .if_pc(if_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input word_t ir, input word_t pc);
    if_valid = 1'b1;
    if_ir    = ir;
    if_pc    = pc;
    #1;
  endtask

  task automatic clear_fwd();
    mem_wen = 1'b0; mem_rd = '0; mem_data = '0;
    wb_wen  = 1'b0; wb_rd  = '0; wb_data  = '0;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_ir = '0; if_pc = '0;
    rs1_data = '0; rs2_data = '0; flush = 1'b0; ex_ready = 1'b1;
    clear_fwd();
    tick(); tick();
    check("rst_valid", 32'(ex_valid), 0);
    check("rst_pc", ex_pc, RST_PC);
    check("rst_alu", 32'(ex_alu_op), 32'(ALU_ADD));
    check("rst_wen", 32'(ex_wen), 0);
    check("rst_op1", ex_op1, 0);
    reset = 1'b0;

    // addi x1,x0,5
    rs1_data = 32'hdead;
    present(32'h0050_0093, 32'h100);
    check("addi_ready", 32'(if_ready), 1);
    check("addi_rs2a", 32'(rs2_addr), 5);
    tick();
    check("addi_valid", 32'(ex_valid), 1);
    check("addi_alu", 32'(ex_alu_op), 32'(ALU_ADD));
    check("addi_op1", ex_op1, 0);
    check("addi_op2", ex_op2, 5);
    check("addi_rd", 32'(ex_rd), 1);
    check("addi_wen", 32'(ex_wen), 1);
    check("addi_pc", ex_pc, 32'h100);

    // sub x3,x1,x2 : MEM beats WB for x1
    mem_wen = 1'b1; mem_rd = 5'd1; mem_data = 32'd7;
    wb_wen  = 1'b1; wb_rd  = 5'd1; wb_data  = 32'd9;
    rs1_data = 32'h55; rs2_data = 32'd2;
    present(32'h4020_81B3, 32'h104);
    tick();
    check("sub_alu", 32'(ex_alu_op), 32'(ALU_SUB));
    check("sub_op1", ex_op1, 7);
    check("sub_op2", ex_op2, 2);
    check("sub_rd", 32'(ex_rd), 3);

    // add x4,x2,x1 : WB forward on rs1, rs2 from regfile
    clear_fwd();
    wb_wen = 1'b1; wb_rd = 5'd2; wb_data = 32'd9;
    rs1_data = 32'h11; rs2_data = 32'h33;
    present(32'h0011_0233, 32'h108);
    tick();
    check("add_op1_wb", ex_op1, 9);
    check("add_op2_rf", ex_op2, 32'h33);
    clear_fwd();

    // addi x0,x0,1 : rd==0 never writes
    present(32'h0010_0013, 32'h10c);
    tick();
    check("x0_wen", 32'(ex_wen), 0);

    // lw x5,0(x0) then add x6,x5,x5
    present(32'h0000_2283, 32'h110);
    tick();
    check("lw_mread", 32'(ex_mem_read), 1);
    check("lw_rd", 32'(ex_rd), 5);
    check("lw_f3", 32'(ex_funct3), 2);
    present(32'h0052_8333, 32'h114);
    check("lu_ready", 32'(if_ready), 0);
    tick();
    check("lu_bubble", 32'(ex_valid), 0);
    check("lu_mread_clr", 32'(ex_mem_read), 0);
    check("lu_ready2", 32'(if_ready), 1);
    wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'h77;
    #1;
    tick();
    check("lu_issue", 32'(ex_valid), 1);
    check("lu_rd", 32'(ex_rd), 6);
    check("lu_op1", ex_op1, 32'h77);
    check("lu_op2", ex_op2, 32'h77);
    clear_fwd();

    // stall 3 cycles with addi x7,x0,1 waiting
    ex_ready = 1'b0;
    present(32'h0010_0393, 32'h118);
    check("stall_ready", 32'(if_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(ex_valid), 1);
      check("stall_rd", 32'(ex_rd), 6);
      check("stall_op1", ex_op1, 32'h77);
    end
    ex_ready = 1'b1;
    #1;
    tick();
    check("adv_rd", 32'(ex_rd), 7);
    check("adv_op2", ex_op2, 1);

    // flush beats hold
    ex_ready = 1'b0; flush = 1'b1;
    present(32'h0020_0413, 32'h11c);
    tick();
    check("flush_valid", 32'(ex_valid), 0);
    check("flush_wen", 32'(ex_wen), 0);
    flush = 1'b0; ex_ready = 1'b1;

    // srai x1,x1,3
    present(32'h4030_d093, 32'h120);
    tick();
    check("srai_alu", 32'(ex_alu_op), 32'(ALU_SRA));
    check("srai_op2", ex_op2, 3);
    check("srai_ill", 32'(ex_illegal), 0);

    // lui x2,0x12345
    present(32'h1234_5137, 32'h124);
    tick();
    check("lui_alu", 32'(ex_alu_op), 32'(ALU_OP2));
    check("lui_op2", ex_op2, 32'h1234_5000);

    // sw x2,-4(x1)
    rs1_data = 32'h1000; rs2_data = 32'habc;
    present(32'hFE20_AE23, 32'h128);
    tick();
    check("sw_op1", ex_op1, 32'h1000);
    check("sw_op2", ex_op2, 32'hFFFF_FFFC);
    check("sw_sdata", ex_store_data, 32'habc);
    check("sw_mwrite", 32'(ex_mem_write), 1);
    check("sw_wen", 32'(ex_wen), 0);

    // slli with funct7[0] set is illegal
    present(32'h0200_9093, 32'h12c);
    tick();
    check("slli_ill", 32'(ex_illegal), 1);
    check("slli_wen", 32'(ex_wen), 0);

    // all-ones word
    present(32'hFFFF_FFFF, 32'h130);
    tick();
    check("ill_valid", 32'(ex_valid), 1);
    check("ill_flag", 32'(ex_illegal), 1);
    check("ill_wen", 32'(ex_wen), 0);

    // reset mid-stream with an instruction offered
    present(32'h0050_0093, 32'h134);
    reset = 1'b1;
    tick();
    check("mrst_valid", 32'(ex_valid), 0);
    check("mrst_pc", ex_pc, RST_PC);
    check("mrst_ill", 32'(ex_illegal), 0);
    check("mrst_op2", ex_op2, 0);
    check("mrst_alu", 32'(ex_alu_op), 32'(ALU_ADD));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
